key_matrix_responder: RTL and testbench

//  Synthesizable 4x4 keypad-matrix emulator; answers key_scan's row drive the way a physical keypad does.
//  A command (key code + hold time) makes the block close one contact. key_col then answers whatever key_row is driven.

---
 rtl/key_matrix_responder.sv | 134 +++++++++++++
 tb/tb_key_matrix_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_matrix_responder.sv
// key_matrix_responder: 4x4 keypad emulator that answers a scanner's row drive.
// Build option KEY_BOUNCE_EN adds press/release contact bounce phases.
module key_matrix_responder #(
  parameter int HOLD_W     = 24,
  parameter int BOUNCE_CYC = 2000,
  parameter int TOGGLE_DIV = 37
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic [3:0]        key_row,
  output logic [3:0]        key_col,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIN,
    S_HOLD,
    S_BOUT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [3:0]        key_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic              contact;
  logic              accept;
  logic              hold_last;

  assign accept    = cmd_vld && cmd_rdy;
  assign hold_last = hold_cnt == HOLD_W'(1);

`ifdef KEY_BOUNCE_EN
  localparam int BW = $clog2(BOUNCE_CYC + 1);
  localparam int TW = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1;

  logic [BW-1:0] bnc_cnt;
  logic [TW-1:0] tgl_cnt;
  logic          bnc_last;
  logic          tgl_last;

  assign bnc_last = bnc_cnt == BW'(BOUNCE_CYC - 1);
  assign tgl_last = tgl_cnt == TW'(TOGGLE_DIV - 1);
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
`ifdef KEY_BOUNCE_EN
      S_IDLE: if (accept)    state_nx = S_BIN;
      S_BIN:  if (bnc_last)  state_nx = S_HOLD;
      S_HOLD: if (hold_last) state_nx = S_BOUT;
      S_BOUT: if (bnc_last)  state_nx = S_DONE;
`else
      S_IDLE: if (accept)    state_nx = S_HOLD;
      S_HOLD: if (hold_last) state_nx = S_DONE;
`endif
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cmd_rdy <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      cmd_rdy <= state_nx == S_IDLE;
      busy    <= state_nx != S_IDLE;
      done    <= state_nx == S_DONE;
    end
  end

  // hold count of zero is stretched to one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q    <= '0;
      hold_cnt <= '0;
    end else if (accept) begin
      key_q    <= cmd_key;
      hold_cnt <= (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
    end else if (state == S_HOLD && !hold_last) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

`ifdef KEY_BOUNCE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      contact <= 1'b0;
      bnc_cnt <= '0;
      tgl_cnt <= '0;
    end else if (state_nx != state) begin
      contact <= (state_nx == S_BIN) || (state_nx == S_HOLD);
      bnc_cnt <= '0;
      tgl_cnt <= '0;
    end else if (state == S_BIN || state == S_BOUT) begin
      if (!bnc_last) bnc_cnt <= bnc_cnt + 1'b1;
      if (tgl_last) begin
        tgl_cnt <= '0;
        contact <= ~contact;
      end else begin
        tgl_cnt <= tgl_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_cfg = BOUNCE_CYC + TOGGLE_DIV;

  always_ff @(posedge clk) begin
    if (rst) contact <= 1'b0;
    else     contact <= state_nx == S_HOLD;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)
      key_col <= 4'hF;
    else if (contact && !key_row[key_q[3:2]])
      key_col <= ~(4'b0001 << key_q[1:0]);
    else
      key_col <= 4'hF;
  end

endmodule

// File: tb/tb_key_matrix_responder.sv
// tb_key_matrix_responder: randomized press scenarios against a timeline model.
// Works for both the default build and KEY_BOUNCE_EN.
module tb_key_matrix_responder;

  localparam int HW = 8;
  localparam int BC = 20;
  localparam int TD = 5;
`ifdef KEY_BOUNCE_EN
  localparam bit BNC = 1'b1;
`else
  localparam bit BNC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_vld;
  logic          cmd_rdy;
  logic [3:0]    cmd_key;
  logic [HW-1:0] cmd_hold;
  logic [3:0]    key_row;
  logic [3:0]    key_col;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_matrix_responder #(
    .HOLD_W(HW),
    .BOUNCE_CYC(BC),
    .TOGGLE_DIV(TD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy),
    .cmd_key(cmd_key),
    .cmd_hold(cmd_hold),
    .key_row(key_row),
    .key_col(key_col),
    .busy(busy),
    .done(done)
  );

  function automatic int heff_f(int h);
    return (h == 0) ? 1 : h;
  endfunction

  function automatic int total_f(int he);
    return he + 1 + (BNC ? 2 * BC : 0);
  endfunction

  // contact state d cycles after the accepting edge
  function automatic bit contact_f(int d, int he);
    int x;
    x = d;
    if (x < 0) return 1'b0;
    if (BNC) begin
      if (x < BC) return ((x / TD) % 2) == 0;
      x = x - BC;
    end
    if (x < he) return 1'b1;
    x = x - he;
    if (BNC && x < BC) return ((x / TD) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] col_f(bit c, logic [3:0] row, int key);
    logic [3:0] m;
    m = 4'hF;
    if (c && row[key / 4] == 1'b0) m[key % 4] = 1'b0;
    return m;
  endfunction

  function automatic logic [3:0] row_f(int mode, int d, int fixed);
    logic [3:0] seq [4];
    seq = '{4'hE, 4'hD, 4'hB, 4'h7};
    case (mode)
      0:       return seq[(d + 4) % 4];
      1:       return 4'($urandom_range(0, 15));
      2:       return 4'hF;
      default: return 4'(fixed);
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_vld = 1'b0;
    cmd_key = '0;
    cmd_hold = '0;
    key_row = 4'h0;
    repeat (3) step;
    checks++;
    if ({key_col, busy, done, cmd_rdy} !== {4'hF, 3'b001}) begin
      errors++;
      $display("FAIL reset_hold got col=%h b/d/r=%b exp col=f b/d/r=001",
               key_col, {busy, done, cmd_rdy});
    end
    rst = 1'b0;
    key_row = 4'hF;
    step;
    checks++;
    if ({key_col, busy, done, cmd_rdy} !== {4'hF, 3'b001}) begin
      errors++;
      $display("FAIL reset_release got col=%h b/d/r=%b exp col=f b/d/r=001",
               key_col, {busy, done, cmd_rdy});
    end
  endtask

  task automatic test_presses;
    int sk[$], sh[$], sm[$], sf[$];
    sk = '{6, 5, 9, 3, 13, 15, 10, 2};
    sh = '{100, 0, 7, 6, 5, 10, 255, 1};
    sm = '{0, 0, 2, 3, 3, 3, 1, 1};
    sf = '{0, 0, 0, 4'b0010, 4'b0111, 4'b0111, 0, 0};
    for (int i = 0; i < 6; i++) begin
      sk.push_back($urandom_range(0, 15));
      sh.push_back($urandom_range(0, 20));
      sm.push_back($urandom_range(0, 3));
      sf.push_back($urandom_range(0, 15));
    end
    for (int s = 0; s < sk.size(); s++) begin
      int he, tot;
      logic [3:0] prev_row;
      logic [3:0] exp_col;
      logic [2:0] exp_st;
      he = heff_f(sh[s]);
      tot = total_f(he);
      checks++;
      if (cmd_rdy !== 1'b1) begin
        errors++;
        $display("FAIL press_ready s=%0d got %b exp 1", s, cmd_rdy);
      end
      cmd_key = 4'(sk[s]);
      cmd_hold = HW'(sh[s]);
      cmd_vld = 1'b1;
      key_row = row_f(sm[s], -1, sf[s]);
      prev_row = key_row;
      step;
      cmd_vld = 1'b0;
      for (int d = 0; d <= tot + 1; d++) begin
        exp_col = col_f(contact_f(d - 1, he), prev_row, sk[s]);
        exp_st = {d < tot, d == tot - 1, d >= tot};
        checks++;
        if (key_col !== exp_col) begin
          errors++;
          $display("FAIL press_col s=%0d key=%0d d=%0d got %h exp %h",
                   s, sk[s], d, key_col, exp_col);
        end
        checks++;
        if ({busy, done, cmd_rdy} !== exp_st) begin
          errors++;
          $display("FAIL press_status s=%0d d=%0d b/d/r got %b exp %b",
                   s, d, {busy, done, cmd_rdy}, exp_st);
        end
        key_row = row_f(sm[s], d, sf[s]);
        prev_row = key_row;
        step;
      end
    end
  endtask

  task automatic test_back_to_back;
    int he, tot;
    logic [2:0] exp_st;
    he = heff_f(4);
    tot = total_f(he);
    cmd_key = 4'd7;
    cmd_hold = HW'(4);
    key_row = 4'hF;
    cmd_vld = 1'b1;
    step;
    for (int d = 0; d <= tot + 1; d++) begin
      if (d < tot)       exp_st = {1'b1, d == tot - 1, 1'b0};
      else if (d == tot) exp_st = 3'b001;
      else               exp_st = 3'b100;
      checks++;
      if ({busy, done, cmd_rdy} !== exp_st) begin
        errors++;
        $display("FAIL b2b_first d=%0d b/d/r got %b exp %b",
                 d, {busy, done, cmd_rdy}, exp_st);
      end
      if (d < tot + 1) step;
    end
    cmd_vld = 1'b0;
    for (int j = 1; j <= tot + 1; j++) begin
      step;
      exp_st = {j < tot, j == tot - 1, j >= tot};
      checks++;
      if ({busy, done, cmd_rdy} !== exp_st) begin
        errors++;
        $display("FAIL b2b_second d=%0d b/d/r got %b exp %b",
                 j, {busy, done, cmd_rdy}, exp_st);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    n = (BNC ? BC : 0) + 3;
    cmd_key = 4'd6;
    cmd_hold = HW'(50);
    key_row = 4'b1101;
    cmd_vld = 1'b1;
    step;
    cmd_vld = 1'b0;
    repeat (n) step;
    checks++;
    if (key_col !== 4'b1011) begin
      errors++;
      $display("FAIL mid_pressed got %h exp b", key_col);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if ({key_col, busy, done, cmd_rdy} !== {4'hF, 3'b001}) begin
        errors++;
        $display("FAIL mid_reset j=%0d got col=%h b/d/r=%b exp col=f b/d/r=001",
                 j, key_col, {busy, done, cmd_rdy});
      end
      step;
    end
  endtask

  initial begin
    test_reset;
    test_presses;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
